matmul_seq_ctrl: RTL and testbench

//  Sequencer for one DEPTHxDEPTH signed matmul pass. Gates host writes into matrix_A/matrix_B load FIFOs.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/mm_load_cnt.sv | 39 +++
 rtl/matmul_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} mm_state_t;

    localparam int unsigned DEFAULT_DEPTH = 8;

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth * depth) + 1;
    endfunction

    function automatic int unsigned drain_default(input int unsigned depth);
        return 2 * depth - 1;
    endfunction

    // Wide enough to hold the larger of the FEED and DRAIN reload values.
    function automatic int unsigned timer_w(input int unsigned depth, input int unsigned drain);
        return $clog2((depth > drain) ? depth : drain) + 1;
    endfunction

endpackage

// File: rtl/mm_load_cnt.sv
// Saturating element-load counter with a full flag and a look-ahead full flag.
module mm_load_cnt
    import matmul_pkg::*;
#(
    parameter int unsigned FULL = DEFAULT_DEPTH * DEFAULT_DEPTH,
    parameter int unsigned W    = $clog2(FULL) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full,
    output logic full_nxt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(FULL))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // full_nxt lets a same-cycle start see the effect of a same-cycle write.
    assign full     = (cnt_q == W'(FULL));
    assign full_nxt = (cnt_d == W'(FULL));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for one DEPTHxDEPTH matmul pass: gates host loads, then runs CLEAR/FEED/DRAIN/DONE.
// Optional MATMUL_CTRL_PERF_EN adds a perf_cycles output (cycles from CLEAR entry to DONE).
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned BITS         = 8,
    parameter int unsigned DRAIN_CYCLES = drain_default(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [idx_w(DEPTH)-1:0]   wr_row,
    input  logic [idx_w(DEPTH)-1:0]   wr_col,
    input  logic signed [BITS-1:0]    wr_data,
    input  logic                      start,
    output logic                      wr_ready,
    output logic                      loaded,
    output logic                      busy,
    output logic                      done,
    output logic                      start_err,
    output logic                      a_WrEn,
    output logic                      b_WrEn,
    output logic [idx_w(DEPTH)-1:0]   fifo_row,
    output logic [idx_w(DEPTH)-1:0]   fifo_col,
    output logic [BITS-1:0]           fifo_d,
    output logic                      a_en,
    output logic                      b_en,
    output logic                      acc_clr
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam int unsigned TW = timer_w(DEPTH, DRAIN_CYCLES);

    mm_state_t     state_q;
    logic [TW-1:0] timer_q;
    logic          a_full, a_full_nxt, b_full, b_full_nxt;
    logic          loaded_upd, cnt_clr;

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign a_WrEn   = wr_en & ~wr_sel & wr_ready;
    assign b_WrEn   = wr_en & wr_sel & wr_ready;
    assign fifo_row = wr_row;
    assign fifo_col = wr_col;
    assign fifo_d   = wr_data;

    assign loaded     = a_full & b_full;
    assign loaded_upd = a_full_nxt & b_full_nxt;
    // The FIFOs are empty once DRAIN ends, so both counts drop on DONE entry.
    assign cnt_clr    = (state_q == DRAIN) && (timer_q == '0);

    mm_load_cnt #(
        .FULL (DEPTH * DEPTH),
        .W    (cnt_w(DEPTH))
    ) u_a_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (a_WrEn),
        .clr      (cnt_clr),
        .full     (a_full),
        .full_nxt (a_full_nxt)
    );

    mm_load_cnt #(
        .FULL (DEPTH * DEPTH),
        .W    (cnt_w(DEPTH))
    ) u_b_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (b_WrEn),
        .clr      (cnt_clr),
        .full     (b_full),
        .full_nxt (b_full_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            acc_clr   <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            acc_clr   <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (loaded_upd) begin
                            state_q <= CLEAR;
                            acc_clr <= 1'b1;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_q <= FEED;
                    timer_q <= TW'(DEPTH - 1);
                    a_en    <= 1'b1;
                    b_en    <= 1'b1;
                end
                FEED: begin
                    if (timer_q == '0) begin
                        state_q <= DRAIN;
                        timer_q <= TW'(DRAIN_CYCLES - 1);
                        a_en    <= 1'b0;
                        b_en    <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DRAIN: begin
                    if (timer_q == '0) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q  <= '0;
            perf_cycles <= '0;
        end else begin
            if (state_q == IDLE) begin
                perf_cnt_q <= '0;
            end else begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if (state_q == DONE) begin
                perf_cycles <= perf_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized bench for matmul_seq_ctrl against a cycle-offset reference model.
// Define MATMUL_CTRL_PERF_EN for both DUT and bench to also check perf_cycles.
module tb_matmul_seq_ctrl;

    localparam int D   = 8;
    localparam int DR  = 2 * D - 1;
    localparam int NN  = D * D;
    localparam int END = D + DR + 2;  // pass-relative cycle carrying done
    localparam int IW  = $clog2(D);

    logic          clk = 1'b0;
    logic          rst, wr_en, wr_sel, start;
    logic [IW-1:0] wr_row, wr_col;
    logic [7:0]    wr_data;
    logic          wr_ready, loaded, busy, done, start_err, a_WrEn, b_WrEn;
    logic [IW-1:0] fifo_row, fifo_col;
    logic [7:0]    fifo_d;
    logic          a_en, b_en, acc_clr;
`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 clk = ~clk;

    matmul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .wr_ready  (wr_ready),
        .loaded    (loaded),
        .busy      (busy),
        .done      (done),
        .start_err (start_err),
        .a_WrEn    (a_WrEn),
        .b_WrEn    (b_WrEn),
        .fifo_row  (fifo_row),
        .fifo_col  (fifo_col),
        .fifo_d    (fifo_d),
        .a_en      (a_en),
        .b_en      (b_en),
        .acc_clr   (acc_clr)
`ifdef MATMUL_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: element counts, pass-relative cycle (-1 when idle), pending error.
    int m_a = 0, m_b = 0, m_t = -1, m_perf = 0;
    bit m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit we, input bit sel, input int row, input int col,
                        input int data, input bit st);
        bit idle;
        @(negedge clk);
        idle = (m_t < 0);
        check("wr_ready", 32'(wr_ready), 32'(idle));
        check("busy", 32'(busy), 32'(!idle));
        check("loaded", 32'(loaded), 32'(m_a == NN && m_b == NN));
        check("acc_clr", 32'(acc_clr), 32'(m_t == 1));
        check("a_en", 32'(a_en), 32'(m_t >= 2 && m_t <= D + 1));
        check("b_en", 32'(b_en), 32'(m_t >= 2 && m_t <= D + 1));
        check("done", 32'(done), 32'(m_t == END));
        check("start_err", 32'(start_err), 32'(m_err));
`ifdef MATMUL_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, 32'(m_perf));
`endif
        rst     = r;
        wr_en   = we;
        wr_sel  = sel;
        wr_row  = row[IW-1:0];
        wr_col  = col[IW-1:0];
        wr_data = data[7:0];
        start   = st;
        #1;
        check("a_WrEn", 32'(a_WrEn), 32'(we && !sel && idle));
        check("b_WrEn", 32'(b_WrEn), 32'(we && sel && idle));
        check("fifo_row", 32'(fifo_row), 32'(row % D));
        check("fifo_col", 32'(fifo_col), 32'(col % D));
        check("fifo_d", 32'(fifo_d), 32'(data % 256));
        if (r) begin
            m_a = 0; m_b = 0; m_t = -1; m_err = 1'b0; m_perf = 0;
        end else begin
            m_err = 1'b0;
            if (m_t < 0) begin
                if (we) begin
                    if (sel) m_b = (m_b < NN) ? m_b + 1 : NN;
                    else     m_a = (m_a < NN) ? m_a + 1 : NN;
                end
                if (st) begin
                    if (m_a == NN && m_b == NN) m_t = 1;
                    else                        m_err = 1'b1;
                end
            end else if (m_t == END) begin
                m_t    = -1;
                m_perf = END - 1;
            end else begin
                m_t++;
                if (m_t == END) begin
                    m_a = 0;
                    m_b = 0;
                end
            end
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic rand_wr_step(input bit st);
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
             int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)), st);
    endtask

    task automatic load_all(input int nb);
        for (int i = 0; i < NN; i++)
            step(1'b0, 1'b1, 1'b0, i / D, i % D, int'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < nb; i++)
            step(1'b0, 1'b1, 1'b1, i / D, i % D, int'($urandom_range(0, 255)), 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Start with nothing loaded is rejected.
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        repeat (3) idle_step();

        // 64 A + 63 B leaves loaded low; the last B raises it.
        load_all(NN - 1);
        repeat (2) idle_step();
        step(1'b0, 1'b1, 1'b1, D - 1, D - 1, 8'h5a, 1'b0);
        idle_step();

        // Full pass with writes and starts thrown in while busy.
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < END + 3; i++) rand_wr_step(1'b1);

        // Last write and start in the same cycle: start must see the updated count.
        load_all(NN - 1);
        step(1'b0, 1'b1, 1'b1, D - 1, D - 1, 8'h11, 1'b1);
        for (int i = 0; i < END + 2; i++) idle_step();

        // Reset mid-DRAIN.
        load_all(NN);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < D + 6; i++) idle_step();
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < END; i++) idle_step();

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            step(1'($urandom_range(0, 799) == 0), 1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                 int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
